// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared widths, control-vector layout and register-update selection for the ID/EX register.
package id_ex_pipe_reg_pkg;

   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned REG_AW_DEF  = 5;
   localparam int unsigned ALUOP_W_DEF = 3;

   typedef struct packed {
      logic reg_wr;
      logic alu_src;
      logic reg_dst;
      logic mem_to_reg;
      logic mem_wr;
      logic branch;
      logic jump;
      logic ext_op;
      logic r_type;
   } ctrl_t;

   // A bubble must never write a register, memory or redirect the PC.
   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      ACT_LOAD,
      ACT_HOLD,
      ACT_BUBBLE,
      ACT_CLEAR
   } reg_act_e;

   function automatic reg_act_e sel_action(input logic rst, input logic flush,
                                           input logic hazard, input logic stall);
      if (rst)         return ACT_CLEAR;
      else if (flush)  return ACT_BUBBLE;
      else if (hazard) return ACT_BUBBLE;
      else if (stall)  return ACT_HOLD;
      else             return ACT_LOAD;
   endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side inputs, EX-side registered outputs and pipeline control of the ID/EX register.
interface id_ex_pipe_reg_if
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned REG_AW  = REG_AW_DEF,
   parameter int unsigned ALUOP_W = ALUOP_W_DEF
);
   logic                Stall;
   logic                Flush;
   logic                Hazard_Stall;

   logic [REG_AW-1:0]   IDin_Rs;
   logic [DATA_W-1:0]   IDin_PC4, IDin_Jtarg, IDin_busA, IDin_busB;
   logic [REG_AW-1:0]   IDin_Rt, IDin_Rd;
   logic [5:0]          IDin_func;
   logic [15:0]         IDin_immd;
   logic                IDin_RegWr, IDin_ALUSrc, IDin_RegDst, IDin_MemtoReg, IDin_MemWr;
   logic                IDin_Branch, IDin_Jump, IDin_ExtOp, IDin_R_type;
   logic [ALUOP_W-1:0]  IDin_ALUop;

   logic [DATA_W-1:0]   EXin_PC4, EXin_Jtarg, EXin_busA, EXin_busB;
   logic [REG_AW-1:0]   EXin_Rt, EXin_Rd;
   logic [5:0]          EXin_func;
   logic [15:0]         EXin_immd;
   logic                EXin_RegWr, EXin_ALUSrc, EXin_RegDst, EXin_MemtoReg, EXin_MemWr;
   logic                EXin_Branch, EXin_Jump, EXin_ExtOp, EXin_R_type;
   logic [ALUOP_W-1:0]  EXin_ALUop;
   logic                EXin_Valid;

   modport master (
      output Stall, Flush,
      output IDin_Rs, IDin_PC4, IDin_Jtarg, IDin_busA, IDin_busB, IDin_Rt, IDin_Rd,
             IDin_func, IDin_immd, IDin_RegWr, IDin_ALUSrc, IDin_RegDst, IDin_MemtoReg,
             IDin_MemWr, IDin_Branch, IDin_Jump, IDin_ExtOp, IDin_R_type, IDin_ALUop,
      input  Hazard_Stall,
      input  EXin_PC4, EXin_Jtarg, EXin_busA, EXin_busB, EXin_Rt, EXin_Rd, EXin_func,
             EXin_immd, EXin_RegWr, EXin_ALUSrc, EXin_RegDst, EXin_MemtoReg, EXin_MemWr,
             EXin_Branch, EXin_Jump, EXin_ExtOp, EXin_R_type, EXin_ALUop, EXin_Valid
   );

   modport slave (
      input  Stall, Flush,
      input  IDin_Rs, IDin_PC4, IDin_Jtarg, IDin_busA, IDin_busB, IDin_Rt, IDin_Rd,
             IDin_func, IDin_immd, IDin_RegWr, IDin_ALUSrc, IDin_RegDst, IDin_MemtoReg,
             IDin_MemWr, IDin_Branch, IDin_Jump, IDin_ExtOp, IDin_R_type, IDin_ALUop,
      output Hazard_Stall,
      output EXin_PC4, EXin_Jtarg, EXin_busA, EXin_busB, EXin_Rt, EXin_Rd, EXin_func,
             EXin_immd, EXin_RegWr, EXin_ALUSrc, EXin_RegDst, EXin_MemtoReg, EXin_MemWr,
             EXin_Branch, EXin_Jump, EXin_ExtOp, EXin_R_type, EXin_ALUop, EXin_Valid
   );

endinterface

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the ID instruction.
module hazard_detect #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              rst,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic              ex_mem_to_reg,
   input  logic              ex_reg_wr,
   input  logic              ex_reg_dst,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_r_type,
   input  logic              id_mem_wr,
   input  logic              id_branch,
   output logic              hazard_stall
);

   logic [REG_AW-1:0] ex_dst;
   logic              rt_used;

   always_comb begin
      ex_dst       = ex_reg_dst ? ex_rd : ex_rt;
      rt_used      = id_r_type | id_mem_wr | id_branch;
      hazard_stall = ex_valid & ex_mem_to_reg & ex_reg_wr & (ex_dst != '0) &
                     ((ex_dst == id_rs) | (rt_used & (ex_dst == id_rt)));
      // A squashed or reset ID instruction has nothing to wait for.
      if (rst || flush) hazard_stall = 1'b0;
   end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble insertion on flush and load-use, and hold on external stall.
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned REG_AW  = REG_AW_DEF,
   parameter int unsigned ALUOP_W = ALUOP_W_DEF
) (
   input  logic            Clk,
   input  logic            Reset,
   id_ex_pipe_reg_if.slave bus
);

   logic [DATA_W-1:0]  pc4_q, jtarg_q, busa_q, busb_q;
   logic [REG_AW-1:0]  rt_q, rd_q;
   logic [5:0]         func_q;
   logic [15:0]        immd_q;
   logic [ALUOP_W-1:0] aluop_q;
   ctrl_t              ctrl_q, id_ctrl;
   logic               valid_q;
   logic               hazard;
   reg_act_e           act;

   assign id_ctrl = '{reg_wr:     bus.IDin_RegWr,
                      alu_src:    bus.IDin_ALUSrc,
                      reg_dst:    bus.IDin_RegDst,
                      mem_to_reg: bus.IDin_MemtoReg,
                      mem_wr:     bus.IDin_MemWr,
                      branch:     bus.IDin_Branch,
                      jump:       bus.IDin_Jump,
                      ext_op:     bus.IDin_ExtOp,
                      r_type:     bus.IDin_R_type};

   hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
      .rst           (Reset),
      .flush         (bus.Flush),
      .ex_valid      (valid_q),
      .ex_mem_to_reg (ctrl_q.mem_to_reg),
      .ex_reg_wr     (ctrl_q.reg_wr),
      .ex_reg_dst    (ctrl_q.reg_dst),
      .ex_rt         (rt_q),
      .ex_rd         (rd_q),
      .id_rs         (bus.IDin_Rs),
      .id_rt         (bus.IDin_Rt),
      .id_r_type     (bus.IDin_R_type),
      .id_mem_wr     (bus.IDin_MemWr),
      .id_branch     (bus.IDin_Branch),
      .hazard_stall  (hazard)
   );

   always_comb act = sel_action(Reset, bus.Flush, hazard, bus.Stall);

   always_ff @(posedge Clk) begin
      unique case (act)
         ACT_CLEAR, ACT_BUBBLE: begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_BUBBLE;
            pc4_q   <= '0;
            jtarg_q <= '0;
            busa_q  <= '0;
            busb_q  <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            func_q  <= '0;
            immd_q  <= '0;
            aluop_q <= '0;
         end
         ACT_HOLD: ;
         ACT_LOAD: begin
            valid_q <= 1'b1;
            ctrl_q  <= id_ctrl;
            pc4_q   <= bus.IDin_PC4;
            jtarg_q <= bus.IDin_Jtarg;
            busa_q  <= bus.IDin_busA;
            busb_q  <= bus.IDin_busB;
            rt_q    <= bus.IDin_Rt;
            rd_q    <= bus.IDin_Rd;
            func_q  <= bus.IDin_func;
            immd_q  <= bus.IDin_immd;
            aluop_q <= bus.IDin_ALUop;
         end
      endcase
   end

   assign bus.Hazard_Stall  = hazard;
   assign bus.EXin_Valid    = valid_q;
   assign bus.EXin_PC4      = pc4_q;
   assign bus.EXin_Jtarg    = jtarg_q;
   assign bus.EXin_busA     = busa_q;
   assign bus.EXin_busB     = busb_q;
   assign bus.EXin_Rt       = rt_q;
   assign bus.EXin_Rd       = rd_q;
   assign bus.EXin_func     = func_q;
   assign bus.EXin_immd     = immd_q;
   assign bus.EXin_ALUop    = aluop_q;
   assign bus.EXin_RegWr    = ctrl_q.reg_wr;
   assign bus.EXin_ALUSrc   = ctrl_q.alu_src;
   assign bus.EXin_RegDst   = ctrl_q.reg_dst;
   assign bus.EXin_MemtoReg = ctrl_q.mem_to_reg;
   assign bus.EXin_MemWr    = ctrl_q.mem_wr;
   assign bus.EXin_Branch   = ctrl_q.branch;
   assign bus.EXin_Jump     = ctrl_q.jump;
   assign bus.EXin_ExtOp    = ctrl_q.ext_op;
   assign bus.EXin_R_type   = ctrl_q.r_type;

endmodule
